tlu_trigger_buffer: RTL and testbench

Downstream stage of the TLU trigger-number control block. It captures each trigger number delivered on the `ts_2a`/`tn2a` pair and tags it with a free-running timestamp. It buffers the tagged records in a FIFO and presents them to the Aurora transmit path over a valid/ready stream. It also reports dropped triggers and, when configured, discontinuities in the trigger-number sequence.

---
 rtl/tlu_pkg.sv | 35 +++
 rtl/tlu_tb_fifo.sv | 61 ++++++
 rtl/tlu_trigger_buffer.sv | 129 ++++++++++++
 tb/tb_tlu_trigger_buffer.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tlu_pkg.sv
// Shared record layout, flag indices and tracker states for the TLU trigger buffer.
package tlu_pkg;

  localparam int REC_W    = 64;
  localparam int TS_LSB   = 0;
  localparam int TN_LSB   = 32;
  localparam int TN_W     = 16;
  localparam int FLAG_LSB = 60;
  localparam int FLAG_W   = 4;

  localparam int FLAG_OVF   = 0;
  localparam int FLAG_SEQ   = 1;
  localparam int FLAG_FIRST = 2;

  typedef enum logic {
    INIT  = 1'b0,
    TRACK = 1'b1
  } trk_state_t;

  function automatic logic [REC_W-1:0] pack_record(input logic [FLAG_W-1:0] flags,
                                                    input logic [TN_W-1:0]   tn,
                                                    input logic [31:0]       ts);
    logic [REC_W-1:0] rec;
    rec = '0;
    rec[FLAG_LSB +: FLAG_W] = flags;
    rec[TN_LSB +: TN_W]     = tn;
    rec[TS_LSB +: 32]       = ts;
    return rec;
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/tlu_tb_fifo.sv
// Synchronous FIFO with a first-word-fall-through output register; fill counts
// the array entries plus the output register.
module tlu_tb_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  output logic                     full,
  output logic                     valid,
  input  logic                     ready,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   fill
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg, rd_ptr_reg;
  logic [AW:0]      mem_cnt_reg, fill_reg;
  logic             out_valid_reg;
  logic [WIDTH-1:0] dout_reg;
  logic             wr, pop, load;

  assign full  = (fill_reg == (AW+1)'(DEPTH));
  assign wr    = push & ~full;
  assign pop   = out_valid_reg & ready;
  // Refill the output register whenever it is empty or being drained this cycle.
  assign load  = (mem_cnt_reg != '0) & (~out_valid_reg | pop);
  assign valid = out_valid_reg;
  assign dout  = dout_reg;
  assign fill  = fill_reg;

  always_ff @(posedge clk) begin
    if (wr) mem[wr_ptr_reg] <= din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      mem_cnt_reg   <= '0;
      fill_reg      <= '0;
      out_valid_reg <= 1'b0;
      dout_reg      <= '0;
    end else begin
      if (wr) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (load) begin
        rd_ptr_reg <= rd_ptr_reg + AW'(1);
        dout_reg   <= mem[rd_ptr_reg];
      end
      mem_cnt_reg <= mem_cnt_reg + (AW+1)'(wr) - (AW+1)'(load);
      fill_reg    <= fill_reg + (AW+1)'(wr) - (AW+1)'(pop);
      if (load)     out_valid_reg <= 1'b1;
      else if (pop) out_valid_reg <= 1'b0;
    end
  end

endmodule

// File: rtl/tlu_trigger_buffer.sv
// Timestamps TLU trigger numbers, buffers them for the Aurora stream and counts drops.
// Define TLU_SEQ_CHECK_EN to build the trigger-number sequence tracker.
module tlu_trigger_buffer
  import tlu_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int TS_W  = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ts_2a,
  input  logic [31:0]            tn2a,
  input  logic                   clr_cnt,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [63:0]            m_data,
  output logic [$clog2(DEPTH):0] fill,
  output logic [15:0]            drop_cnt,
  output logic [15:0]            seq_err_cnt
);

  logic [TS_W-1:0] ts_reg;
  logic            ts_2a_d_reg;
  logic            ovf_pend_reg, first_pend_reg;
  logic [15:0]     drop_cnt_reg;
  logic            cap, full, store, drop, seq_err;
  logic [15:0]     tn;
  logic [3:0]      flags;
  logic [63:0]     rec;
  logic            unused_tn_hi;

  assign cap          = ts_2a & ~ts_2a_d_reg;
  assign tn           = tn2a[15:0];
  assign unused_tn_hi = &{1'b0, tn2a[31:16]};
  // Full comes from the registered fill, so a same-cycle pop never frees room.
  assign store        = cap & ~full;
  assign drop         = cap & full;

  always_comb begin
    flags             = '0;
    flags[FLAG_OVF]   = ovf_pend_reg;
    flags[FLAG_SEQ]   = seq_err;
    flags[FLAG_FIRST] = first_pend_reg;
  end

  assign rec = pack_record(flags, tn, ts_reg[31:0]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ts_reg         <= '0;
      ts_2a_d_reg    <= 1'b0;
      ovf_pend_reg   <= 1'b0;
      first_pend_reg <= 1'b1;
      drop_cnt_reg   <= '0;
    end else begin
      ts_reg      <= ts_reg + TS_W'(1);
      ts_2a_d_reg <= ts_2a;
      if (store)     ovf_pend_reg <= 1'b0;
      else if (drop) ovf_pend_reg <= 1'b1;
      if (cap) first_pend_reg <= 1'b0;
      if (clr_cnt)   drop_cnt_reg <= '0;
      else if (drop) drop_cnt_reg <= sat_inc(drop_cnt_reg);
    end
  end

  assign drop_cnt = drop_cnt_reg;

`ifdef TLU_SEQ_CHECK_EN
  trk_state_t  state_reg, state_next;
  logic [15:0] expected_reg, expected_next;
  logic [15:0] seq_cnt_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= INIT;
      expected_reg <= '0;
    end else begin
      state_reg    <= state_next;
      expected_reg <= expected_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      INIT:    if (cap) state_next = TRACK;
      TRACK:   state_next = TRACK;
      default: state_next = INIT;
    endcase
  end

  // Dropped captures still advance the expected number.
  always_comb begin
    seq_err       = 1'b0;
    expected_next = expected_reg;
    if (cap) begin
      expected_next = tn + 16'd1;
      seq_err       = (state_reg == TRACK) && (tn != expected_reg);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)          seq_cnt_reg <= '0;
    else if (clr_cnt) seq_cnt_reg <= '0;
    else if (seq_err) seq_cnt_reg <= sat_inc(seq_cnt_reg);
  end

  assign seq_err_cnt = seq_cnt_reg;
`else
  assign seq_err     = 1'b0;
  assign seq_err_cnt = 16'h0000;
`endif

  tlu_tb_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (REC_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (store),
    .din   (rec),
    .full  (full),
    .valid (m_valid),
    .ready (m_ready),
    .dout  (m_data),
    .fill  (fill)
  );

endmodule

// File: tb/tb_tlu_trigger_buffer.sv
// Self-checking bench for tlu_trigger_buffer: spec-level scoreboard model plus
// table-driven and directed corner-case sequences.
module tb_tlu_trigger_buffer;

  localparam int DEPTH = 16;
`ifdef TLU_SEQ_CHECK_EN
  localparam bit SEQ_EN = 1'b1;
`else
  localparam bit SEQ_EN = 1'b0;
`endif

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic                   ts_2a = 1'b0;
  logic [31:0]            tn2a = '0;
  logic                   clr_cnt = 1'b0;
  logic                   m_ready = 1'b0;
  logic                   m_valid;
  logic [63:0]            m_data;
  logic [$clog2(DEPTH):0] fill;
  logic [15:0]            drop_cnt;
  logic [15:0]            seq_err_cnt;

  always #5 clk = ~clk;

  tlu_trigger_buffer #(.DEPTH(DEPTH), .TS_W(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .ts_2a       (ts_2a),
    .tn2a        (tn2a),
    .clr_cnt     (clr_cnt),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .m_data      (m_data),
    .fill        (fill),
    .drop_cnt    (drop_cnt),
    .seq_err_cnt (seq_err_cnt)
  );

  int checks = 0;
  int failures = 0;

  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endfunction

  // Scoreboard model state
  logic [63:0] sb[$];
  logic [63:0] got_q[$];
  int          m_fill;
  logic [15:0] m_drop, m_seq, m_exp;
  logic [31:0] m_ts;
  bit          m_tracked, m_first, m_ovfp, m_prev;
  bit          prev_stall;
  logic [63:0] prev_data;

  always @(negedge clk) begin : monitor
    logic [63:0] exp_rec;
    bit          cap, seq;
    if (rst) begin
      check("rst_m_valid", m_valid, 0);
      check("rst_m_data", m_data, 0);
      check("rst_fill", fill, 0);
      check("rst_drop_cnt", drop_cnt, 0);
      check("rst_seq_err_cnt", seq_err_cnt, 0);
      sb.delete();
      m_fill = 0; m_drop = 0; m_seq = 0; m_exp = 0; m_ts = 0;
      m_tracked = 0; m_first = 1; m_ovfp = 0; m_prev = 0;
      prev_stall = 0; prev_data = 0;
    end else begin
      check("fill", fill, 64'(m_fill));
      check("drop_cnt", drop_cnt, m_drop);
      check("seq_err_cnt", seq_err_cnt, m_seq);
      if (prev_stall) begin
        check("stall_valid", m_valid, 1);
        check("stall_data", m_data, prev_data);
      end
      if (m_valid && m_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_record", 1, 0);
        end else begin
          exp_rec = sb.pop_front();
          check("record", m_data, exp_rec);
        end
        got_q.push_back(m_data);
        $display("REC tn=%04h ts=%08h flags=%1h", m_data[47:32], m_data[31:0], m_data[63:60]);
      end
      cap = ts_2a & ~m_prev;
      m_prev = ts_2a;
      if (cap) begin
        seq = SEQ_EN && m_tracked && (tn2a[15:0] != m_exp);
        m_exp = tn2a[15:0] + 16'd1;
        m_tracked = 1;
        if (m_fill == DEPTH) begin
          if (m_drop != 16'hFFFF) m_drop++;
          m_ovfp = 1;
        end else begin
          sb.push_back({1'b0, m_first, seq, m_ovfp, 12'h000, tn2a[15:0], m_ts});
          m_ovfp = 0;
          m_fill++;
        end
        m_first = 0;
        if (seq && m_seq != 16'hFFFF) m_seq++;
      end
      if (clr_cnt) begin
        m_drop = 0;
        m_seq = 0;
      end
      if (m_valid && m_ready) m_fill--;
      m_ts++;
      prev_stall = m_valid & ~m_ready;
      prev_data = m_data;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; ts_2a = 1'b0; clr_cnt = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
  endtask

  task automatic pulse(input logic [15:0] tn, input int gap);
    ts_2a = 1'b1;
    tn2a = {16'hABCD, tn};
    tick();
    ts_2a = 1'b0;
    repeat (gap) tick();
  endtask

  task automatic wait_count(input int cnt);
    int n = 0;
    while (got_q.size() < cnt && n < 200) begin
      tick();
      n++;
    end
    check("record_wait", got_q.size() >= cnt, 1);
  endtask

  // Capture in the current cycle must show m_valid exactly two cycles later.
  task automatic latency_check(input logic [15:0] tn, input logic [31:0] exp_ts);
    ts_2a = 1'b1;
    tn2a = {16'h5A5A, tn};
    @(negedge clk); check("lat_c0_valid", m_valid, 0);
    tick();
    ts_2a = 1'b0;
    @(negedge clk); check("lat_c1_valid", m_valid, 0);
    tick();
    @(negedge clk);
    check("lat_c2_valid", m_valid, 1);
    check("lat_tn", m_data[47:32], tn);
    check("lat_first", m_data[62], 1);
    check("lat_ts", m_data[31:0], exp_ts);
    tick();
  endtask

  typedef struct {
    logic [15:0] tn;
    bit          seq;
    bit          first;
  } vec_t;

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin : stim
    vec_t vecs[5];
    int   maxf;
    int   n;
    vecs[0] = '{16'h0007, 1'b0, 1'b1};
    vecs[1] = '{16'h0008, 1'b0, 1'b0};
    vecs[2] = '{16'h000A, 1'b1, 1'b0};
    vecs[3] = '{16'hFFFF, 1'b1, 1'b0};
    vecs[4] = '{16'h0000, 1'b0, 1'b0};

    // Single trigger latency and fields
    do_reset();
    m_ready = 1'b1;
    repeat (3) tick();
    latency_check(16'h0005, 32'd3);
    repeat (3) tick();

    // Held-high strobe gives one record
    got_q.delete();
    maxf = 0;
    ts_2a = 1'b1;
    tn2a = 32'h0000_0006;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (int'(fill) > maxf) maxf = int'(fill);
      tick();
      if (i == 9) ts_2a = 1'b0;
    end
    check("held_records", got_q.size(), 1);
    check("held_fill_peak", maxf, 1);

    // Overflow: fill to DEPTH, drop three, drain, then OVF/SEQ on next record
    do_reset();
    m_ready = 1'b0;
    for (int i = 1; i <= DEPTH + 3; i++) pulse(16'(i), 2);
    repeat (3) tick();
    @(negedge clk);
    check("ovf_fill", fill, DEPTH);
    check("ovf_drop_cnt", drop_cnt, 3);
    tick();
    got_q.delete();
    m_ready = 1'b1;
    wait_count(DEPTH);
    for (int i = 0; i < DEPTH; i++) check("drain_tn", got_q[i][47:32], 64'(i + 1));
    got_q.delete();
    pulse(16'd100, 3);
    wait_count(1);
    check("ovf_flag", got_q[0][60], 1);
    check("ovf_seq_flag", got_q[0][61], SEQ_EN);
    check("ovf_seq_cnt", seq_err_cnt, SEQ_EN ? 1 : 0);
    clr_cnt = 1'b1;
    tick();
    clr_cnt = 1'b0;
    @(negedge clk);
    check("clr_drop_cnt", drop_cnt, 0);
    check("clr_seq_cnt", seq_err_cnt, 0);
    tick();

    // Table-driven sequence check including 0xFFFF -> 0x0000 wrap
    do_reset();
    m_ready = 1'b1;
    got_q.delete();
    foreach (vecs[i]) pulse(vecs[i].tn, 3);
    wait_count(5);
    foreach (vecs[i]) begin
      check("tbl_tn", got_q[i][47:32], vecs[i].tn);
      check("tbl_seq", got_q[i][61], vecs[i].seq & SEQ_EN);
      check("tbl_first", got_q[i][62], vecs[i].first);
      check("tbl_ovf", got_q[i][60], 0);
    end
    check("tbl_seq_cnt", seq_err_cnt, SEQ_EN ? 2 : 0);

    // Random backpressure: stability and ordering come from the monitor
    for (int i = 0; i < 100; i++) begin
      ts_2a = 1'b1;
      tn2a = $urandom;
      m_ready = 1'($urandom_range(0, 1));
      tick();
      ts_2a = 1'b0;
      repeat ($urandom_range(1, 3)) begin
        m_ready = 1'($urandom_range(0, 1));
        tick();
      end
    end
    m_ready = 1'b1;
    n = 0;
    while (sb.size() != 0 && n < 300) begin
      tick();
      n++;
    end
    check("bp_drained", sb.size(), 0);

    // Reset with five buffered records
    do_reset();
    m_ready = 1'b0;
    for (int i = 0; i < 5; i++) pulse(16'(i + 20), 2);
    repeat (2) tick();
    @(negedge clk);
    check("pre_rst_fill", fill, 5);
    tick();
    rst = 1'b1;
    #1;
    check("midrst_valid", m_valid, 0);
    check("midrst_fill", fill, 0);
    tick();
    tick();
    rst = 1'b0;
    m_ready = 1'b1;
    latency_check(16'h0042, 32'd0);
    repeat (5) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
